// File: rtl/embertrail_dmem_responder.sv
// embertrail_dmem_responder: two-lane load/store responder serialising onto a
// single-port RAM. Lane 1 is always serviced before lane 2. A dual request
// holds lane 2 for one extra cycle, and oStall is raised during that cycle.
// Optional feature macro: EMBERTRAIL_DMEM_ERR_EN (out-of-range detection and
// the oAddrErr pulse). When it is undefined, upper address bits wrap.
`timescale 1ns/1ps

module embertrail_dmem_responder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iReq1,
    input  logic              iWe1,
    input  logic [15:0]       iAddr1,
    input  logic [DATA_W-1:0] iWData1,
    input  logic              iReq2,
    input  logic              iWe2,
    input  logic [15:0]       iAddr2,
    input  logic [DATA_W-1:0] iWData2,
    output logic [DATA_W-1:0] oRData1,
    output logic              oRValid1,
    output logic [DATA_W-1:0] oRData2,
    output logic              oRValid2,
    output logic              oStall,
    output logic              oAddrErr
);

    typedef enum logic {IDLE, LANE2} state_t;

    state_t            state;
    state_t            next_state;

    // Lane-2 request parked while lane 1 of a dual request uses the RAM
    logic              held_we;
    logic [15:0]       held_addr;
    logic [DATA_W-1:0] held_wdata;
    logic              latch_hold;

    // The single access selected for this cycle
    logic              acc_en;
    logic              acc_we;
    logic              acc_lane2;
    logic [15:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic              in_range;

    logic              stall;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rvalid1;
    logic              rvalid2;

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    assign acc_idx = acc_addr[ADDR_W-1:0];

`ifdef EMBERTRAIL_DMEM_ERR_EN
    logic addr_err;

    assign in_range = (acc_addr[15:ADDR_W] == '0);

    // Flag out-of-range accesses in the cycle after the access edge
    always_ff @(posedge iClock) begin
        if (iReset) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= acc_en & ~in_range;
        end
    end

    assign oAddrErr = addr_err;
`else
    logic addr_hi_unused;

    assign in_range       = 1'b1;
    assign addr_hi_unused = ^acc_addr[15:ADDR_W];
    assign oAddrErr       = 1'b0;
`endif

    // State, stall flag and lane-2 holding register
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= IDLE;
            stall      <= 1'b0;
            held_we    <= 1'b0;
            held_addr  <= '0;
            held_wdata <= '0;
        end else begin
            state <= next_state;
            stall <= (next_state == LANE2);
            if (latch_hold) begin
                held_we    <= iWe2;
                held_addr  <= iAddr2;
                held_wdata <= iWData2;
            end
        end
    end

    // Pick the one RAM access for this cycle and the next state
    always_comb begin
        next_state = state;
        latch_hold = 1'b0;
        acc_en     = 1'b0;
        acc_we     = 1'b0;
        acc_lane2  = 1'b0;
        acc_addr   = '0;
        acc_wdata  = '0;
        case (state)
            IDLE: begin
                if (iReq1) begin
                    acc_en    = 1'b1;
                    acc_we    = iWe1;
                    acc_addr  = iAddr1;
                    acc_wdata = iWData1;
                    if (iReq2) begin
                        latch_hold = 1'b1;
                        next_state = LANE2;
                    end
                end else if (iReq2) begin
                    acc_en    = 1'b1;
                    acc_lane2 = 1'b1;
                    acc_we    = iWe2;
                    acc_addr  = iAddr2;
                    acc_wdata = iWData2;
                end
            end
            LANE2: begin
                acc_en     = 1'b1;
                acc_lane2  = 1'b1;
                acc_we     = held_we;
                acc_addr   = held_addr;
                acc_wdata  = held_wdata;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // RAM write port; gated by reset so a held store abandoned by reset never lands
    always_ff @(posedge iClock) begin
        if (!iReset && acc_en && acc_we && in_range) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Registered load data and per-lane valid strobes; data holds between loads
    always_ff @(posedge iClock) begin
        if (iReset) begin
            rdata1  <= '0;
            rdata2  <= '0;
            rvalid1 <= 1'b0;
            rvalid2 <= 1'b0;
        end else begin
            rvalid1 <= acc_en & ~acc_we & ~acc_lane2;
            rvalid2 <= acc_en & ~acc_we & acc_lane2;
            if (acc_en && !acc_we) begin
                if (acc_lane2) begin
                    rdata2 <= in_range ? mem[acc_idx] : '0;
                end else begin
                    rdata1 <= in_range ? mem[acc_idx] : '0;
                end
            end
        end
    end

    assign oRData1  = rdata1;
    assign oRData2  = rdata2;
    assign oRValid1 = rvalid1;
    assign oRValid2 = rvalid2;
    assign oStall   = stall;

endmodule

// File: tb/tb_embertrail_dmem_responder.sv
// Testbench for embertrail_dmem_responder: directed vector table, then
// randomised traffic against a queue-based reference model.
`timescale 1ns/1ps

module tb_embertrail_dmem_responder;

    localparam int AW = 10;

`ifdef EMBERTRAIL_DMEM_ERR_EN
    localparam logic        ERR_EXP = 1'b1;
    localparam logic [15:0] WRAP_D  = 16'h0000;
`else
    localparam logic        ERR_EXP = 1'b0;
    localparam logic [15:0] WRAP_D  = 16'hC0DE;
`endif

    logic        clk = 1'b0;
    logic        iReset, iReq1, iWe1, iReq2, iWe2;
    logic [15:0] iAddr1, iWData1, iAddr2, iWData2;
    logic [15:0] oRData1, oRData2;
    logic        oRValid1, oRValid2, oStall, oAddrErr;

    always #5 clk = ~clk;

    embertrail_dmem_responder #(.ADDR_W(AW), .DATA_W(16)) dut (
        .iClock(clk), .iReset(iReset),
        .iReq1(iReq1), .iWe1(iWe1), .iAddr1(iAddr1), .iWData1(iWData1),
        .iReq2(iReq2), .iWe2(iWe2), .iAddr2(iAddr2), .iWData2(iWData2),
        .oRData1(oRData1), .oRValid1(oRValid1),
        .oRData2(oRData2), .oRValid2(oRValid2),
        .oStall(oStall), .oAddrErr(oAddrErr)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: word array plus a queue of deferred lane-2 accesses
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    logic [15:0] m_mem [0:(1 << AW) - 1];
    acc_t        pend[$];
    logic        m_v1, m_v2, m_err, m_stall;
    logic [15:0] m_d1 = '0, m_d2 = '0;

    task automatic model_access(input logic lane2, input logic we,
                                input logic [15:0] a, input logic [15:0] d);
        logic        ok;
        logic [15:0] data;
        int          idx;
        ok  = 1'b1;
`ifdef EMBERTRAIL_DMEM_ERR_EN
        ok    = (a / (1 << AW)) == 0;
        m_err = !ok;
`endif
        idx = a % (1 << AW);
        if (we) begin
            if (ok) m_mem[idx] = d;
        end else begin
            data = ok ? m_mem[idx] : 16'h0000;
            if (lane2) begin m_v2 = 1'b1; m_d2 = data; end
            else       begin m_v1 = 1'b1; m_d1 = data; end
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, and settle at negedge
    task automatic step(input logic rs, input logic r1, input logic w1,
                        input logic [15:0] a1, input logic [15:0] d1,
                        input logic r2, input logic w2,
                        input logic [15:0] a2, input logic [15:0] d2);
        acc_t h;
        iReset = rs; iReq1 = r1; iWe1 = w1; iAddr1 = a1; iWData1 = d1;
        iReq2 = r2; iWe2 = w2; iAddr2 = a2; iWData2 = d2;
        m_v1 = 1'b0; m_v2 = 1'b0; m_err = 1'b0;
        if (rs) begin
            pend.delete();
            m_d1 = '0;
            m_d2 = '0;
        end else if (pend.size() != 0) begin
            h = pend.pop_front();
            model_access(1'b1, h.we, h.addr, h.wdata);
        end else begin
            if (r1) model_access(1'b0, w1, a1, d1);
            if (r1 && r2) begin
                h.we = w2; h.addr = a2; h.wdata = d2;
                pend.push_back(h);
            end else if (r2) begin
                model_access(1'b1, w2, a2, d2);
            end
        end
        m_stall = (pend.size() != 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int cyc,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all(input int cyc, input logic v1, input logic [15:0] d1,
                             input logic v2, input logic [15:0] d2,
                             input logic st, input logic er);
        chk("rvalid1", cyc, {15'd0, oRValid1}, {15'd0, v1});
        chk("rdata1",  cyc, oRData1, d1);
        chk("rvalid2", cyc, {15'd0, oRValid2}, {15'd0, v2});
        chk("rdata2",  cyc, oRData2, d2);
        chk("stall",   cyc, {15'd0, oStall}, {15'd0, st});
        chk("addrerr", cyc, {15'd0, oAddrErr}, {15'd0, er});
    endtask

    typedef struct {
        logic        rs, r1, w1;
        logic [15:0] a1, d1;
        logic        r2, w2;
        logic [15:0] a2, d2;
        logic        ev1;
        logic [15:0] ed1;
        logic        ev2;
        logic [15:0] ed2;
        logic        est, eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rs, input logic r1, input logic w1,
                                input logic [15:0] a1, input logic [15:0] d1,
                                input logic r2, input logic w2,
                                input logic [15:0] a2, input logic [15:0] d2,
                                input logic ev1, input logic [15:0] ed1,
                                input logic ev2, input logic [15:0] ed2,
                                input logic est, input logic eerr);
        vec_t v;
        v = '{rs, r1, w1, a1, d1, r2, w2, a2, d2, ev1, ed1, ev2, ed2, est, eerr};
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r1, w1, r2, w2, rs;
        logic [15:0] a1, a2, d1, d2;

        iReset = 1'b1; iReq1 = 1'b0; iWe1 = 1'b0; iAddr1 = '0; iWData1 = '0;
        iReq2 = 1'b0; iWe2 = 1'b0; iAddr2 = '0; iWData2 = '0;

        //   rs r1 w1 a1      d1        r2 w2 a2      d2        ev1 ed1       ev2 ed2       st er
        add(1, 0, 0, 16'd0,  16'h0000, 0, 0, 16'd0,  16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0); // reset
        add(0, 1, 1, 16'd5,  16'hBEEF, 0, 0, 16'd0,  16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0); // st BEEF@5
        add(0, 1, 0, 16'd5,  16'h0000, 0, 0, 16'd0,  16'h0000, 1, 16'hBEEF, 0, 16'h0000, 0, 0); // ld @5
        add(0, 0, 0, 16'd0,  16'h0000, 0, 0, 16'd0,  16'h0000, 0, 16'hBEEF, 0, 16'h0000, 0, 0); // hold
        add(0, 1, 1, 16'd10, 16'h1234, 1, 0, 16'd10, 16'h0000, 0, 16'hBEEF, 0, 16'h0000, 1, 0); // st/ld @10
        add(0, 0, 0, 16'd0,  16'h0000, 0, 0, 16'd0,  16'h0000, 0, 16'hBEEF, 1, 16'h1234, 0, 0);
        add(0, 1, 1, 16'd3,  16'h0001, 1, 1, 16'd3,  16'h0002, 0, 16'hBEEF, 0, 16'h1234, 1, 0); // dual st @3
        add(0, 0, 0, 16'd0,  16'h0000, 0, 0, 16'd0,  16'h0000, 0, 16'hBEEF, 0, 16'h1234, 0, 0);
        add(0, 1, 0, 16'd3,  16'h0000, 0, 0, 16'd0,  16'h0000, 1, 16'h0002, 0, 16'h1234, 0, 0); // lane 2 wins
        add(0, 1, 1, 16'd7,  16'h0777, 0, 0, 16'd0,  16'h0000, 0, 16'h0002, 0, 16'h1234, 0, 0);
        add(0, 1, 0, 16'd5,  16'h0000, 1, 0, 16'd7,  16'h0000, 1, 16'hBEEF, 0, 16'h1234, 1, 0); // dual ld
        add(0, 1, 1, 16'd7,  16'hFFFF, 0, 0, 16'd0,  16'h0000, 0, 16'hBEEF, 1, 16'h0777, 0, 0); // dropped
        add(0, 1, 0, 16'd7,  16'h0000, 0, 0, 16'd0,  16'h0000, 1, 16'h0777, 0, 16'h0777, 0, 0);
        add(0, 1, 1, 16'd7,  16'hFFFF, 0, 0, 16'd0,  16'h0000, 0, 16'h0777, 0, 16'h0777, 0, 0); // re-present
        add(0, 1, 0, 16'd7,  16'h0000, 0, 0, 16'd0,  16'h0000, 1, 16'hFFFF, 0, 16'h0777, 0, 0);
        add(0, 1, 0, 16'd5,  16'h0000, 1, 1, 16'd5,  16'hAAAA, 1, 16'hBEEF, 0, 16'h0777, 1, 0); // ld old
        add(0, 0, 0, 16'd0,  16'h0000, 0, 0, 16'd0,  16'h0000, 0, 16'hBEEF, 0, 16'h0777, 0, 0);
        add(0, 0, 0, 16'd0,  16'h0000, 1, 0, 16'd5,  16'h0000, 0, 16'hBEEF, 1, 16'hAAAA, 0, 0); // lane2 only
        add(0, 1, 1, 16'd21, 16'h5A5A, 0, 0, 16'd0,  16'h0000, 0, 16'hBEEF, 0, 16'hAAAA, 0, 0);
        add(0, 1, 1, 16'd20, 16'h1111, 1, 1, 16'd21, 16'h2222, 0, 16'hBEEF, 0, 16'hAAAA, 1, 0);
        add(1, 0, 0, 16'd0,  16'h0000, 0, 0, 16'd0,  16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0); // reset in LANE2
        add(0, 0, 0, 16'd0,  16'h0000, 1, 0, 16'd21, 16'h0000, 0, 16'h0000, 1, 16'h5A5A, 0, 0);
        add(0, 1, 0, 16'd20, 16'h0000, 0, 0, 16'd0,  16'h0000, 1, 16'h1111, 0, 16'h5A5A, 0, 0);
        add(0, 1, 1, 16'd0,  16'hC0DE, 0, 0, 16'd0,  16'h0000, 0, 16'h1111, 0, 16'h5A5A, 0, 0);
        add(0, 1, 0, 16'h0400, 16'h0000, 0, 0, 16'd0, 16'h0000, 1, WRAP_D, 0, 16'h5A5A, 0, ERR_EXP);
        add(0, 0, 0, 16'd0,  16'h0000, 0, 0, 16'd0,  16'h0000, 0, WRAP_D,   0, 16'h5A5A, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rs, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1,
                 tbl[i].r2, tbl[i].w2, tbl[i].a2, tbl[i].d2);
            check_all(i, tbl[i].ev1, tbl[i].ed1, tbl[i].ev2, tbl[i].ed2,
                      tbl[i].est, tbl[i].eerr);
        end

        // Fill a small address pool so every random load reads known data
        for (int a = 0; a < 32; a++) begin
            step(1'b0, 1'b1, 1'b1, 16'(a), 16'($urandom), 1'b0, 1'b0, 16'd0, 16'd0);
            check_all(1000 + a, m_v1, m_d1, m_v2, m_d2, m_stall, m_err);
        end

        for (int n = 0; n < 800; n++) begin
            rs = ($urandom_range(0, 49) == 0);
            r1 = 1'($urandom); w1 = 1'($urandom);
            r2 = 1'($urandom); w2 = 1'($urandom);
            a1 = 16'($urandom_range(0, 31));
            a2 = 16'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a1[15:10] = 6'($urandom_range(1, 63));
            if ($urandom_range(0, 7) == 0) a2[15:10] = 6'($urandom_range(1, 63));
            if ($urandom_range(0, 3) == 0) a2 = a1;
            d1 = 16'($urandom);
            d2 = 16'($urandom);
            step(rs, r1, w1, a1, d1, r2, w2, a2, d2);
            check_all(2000 + n, m_v1, m_d1, m_v2, m_d2, m_stall, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
